// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: opcodes, forward-stage encoding and writer decode shared by the scoreboard.
package hazard_scoreboard_pkg;
  localparam logic [6:0] OP_R_TYPE  = 7'b0110011;
  localparam logic [6:0] OP_I_IMME  = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_U_LUI   = 7'b0110111;
  localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
  typedef enum logic [1:0] {FWD_NONE = 2'b00, FWD_EX_MEM = 2'b01, FWD_MEM_WB = 2'b10} fwd_stage_t;
  function automatic logic writes_rd(input logic [6:0] op);
    return op inside {OP_R_TYPE, OP_I_IMME, OP_LOAD, OP_JAL, OP_JALR, OP_U_LUI, OP_U_AUIPC};
  endfunction
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID bundle in, issue/stall/forward selects out.
interface hazard_scoreboard_if #(parameter int LANES = 2, parameter int LW = $clog2(LANES));
  logic                      flush;
  logic [LANES-1:0]          id_valid;
  logic [LANES-1:0][6:0]     id_op;
  logic [LANES-1:0][4:0]     id_rd, id_rs1, id_rs2;
  logic [LANES-1:0]          issue_mask;
  logic                      stall;
  logic [LANES-1:0][LW+1:0]  ex_fwd_rs1, ex_fwd_rs2;
  logic                      split_state;
  logic [15:0]               stall_cycles;
  modport master(output flush, id_valid, id_op, id_rd, id_rs1, id_rs2,
                 input issue_mask, stall, ex_fwd_rs1, ex_fwd_rs2, split_state, stall_cycles);
  modport slave(input flush, id_valid, id_op, id_rd, id_rs1, id_rs2,
                output issue_mask, stall, ex_fwd_rs1, ex_fwd_rs2, split_state, stall_cycles);
endinterface

// File: rtl/hazard_lane_cmp.sv
// hazard_lane_cmp: matches one source register against every EX and MEM shadow lane.
module hazard_lane_cmp import hazard_scoreboard_pkg::*; #(
  parameter int LANES = 2,
  parameter int LW    = $clog2(LANES)
) (
  input  logic [4:0]            rs,
  input  logic [LANES-1:0]      ex_w,
  input  logic [LANES-1:0]      ex_ld,
  input  logic [LANES-1:0][4:0] ex_rd,
  input  logic [LANES-1:0]      mem_w,
  input  logic [LANES-1:0][4:0] mem_rd,
  output fwd_stage_t            stage,
  output logic [LW-1:0]         lane,
  output logic                  load_use
);
  // ascending scans let the youngest lane win; EX scanned last so it overrides MEM
  always_comb begin
    stage = FWD_NONE;
    lane = '0;
    load_use = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (rs != '0 && mem_w[i] && mem_rd[i] == rs) begin
        stage = FWD_MEM_WB;
        lane = LW'(i);
      end
    for (int i = 0; i < LANES; i++)
      if (rs != '0 && ex_w[i] && ex_rd[i] == rs) begin
        if (ex_ld[i]) load_use = 1'b1;
        else begin
          stage = FWD_EX_MEM;
          lane = LW'(i);
        end
      end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: multi-issue ID hazard check with load-use stall, bundle splitting and forward selects.
module hazard_scoreboard import hazard_scoreboard_pkg::*; #(
  parameter int LANES = 2,
  parameter int LW    = $clog2(LANES)
) (
  input logic               clk,
  input logic               rst_n,
  hazard_scoreboard_if.slave bus
);
  logic [LANES-1:0]          wr, ld, cand, keep, issue, lu1, lu2;
  logic [LANES-1:0]          pending, nxt_pending, ex_w, ex_ld, mem_w;
  logic [LANES-1:0][4:0]     ex_rd, mem_rd;
  logic [LANES-1:0][LW+1:0]  fwd1, fwd2;
  fwd_stage_t                st1 [LANES];
  fwd_stage_t                st2 [LANES];
  logic [LW-1:0]             ln1 [LANES];
  logic [LW-1:0]             ln2 [LANES];
  logic                      split, nxt_split, hit, stall;
  logic [15:0]               cnt;
  assign cand = bus.id_valid & pending;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign wr[l] = bus.id_valid[l] && writes_rd(bus.id_op[l]) && bus.id_rd[l] != '0;
    assign ld[l] = bus.id_op[l] == OP_LOAD;
    hazard_lane_cmp #(.LANES(LANES), .LW(LW)) u_rs1 (
      .rs(bus.id_rs1[l]), .ex_w, .ex_ld, .ex_rd, .mem_w, .mem_rd,
      .stage(st1[l]), .lane(ln1[l]), .load_use(lu1[l]));
    hazard_lane_cmp #(.LANES(LANES), .LW(LW)) u_rs2 (
      .rs(bus.id_rs2[l]), .ex_w, .ex_ld, .ex_rd, .mem_w, .mem_rd,
      .stage(st2[l]), .lane(ln2[l]), .load_use(lu2[l]));
  end
  // oldest consumer of an older in-bundle writer sets the split point
  always_comb begin
    hit = 1'b0;
    keep = '0;
    for (int j = 0; j < LANES; j++)
      for (int i = 0; i < j; i++)
        if (!hit && cand[i] && wr[i] && cand[j] &&
            (bus.id_rd[i] == bus.id_rs1[j] || bus.id_rd[i] == bus.id_rs2[j])) begin
          hit = 1'b1;
          keep = LANES'((1 << j) - 1);
        end
  end
  always_comb begin
    issue = '0;
    stall = 1'b0;
    nxt_pending = pending;
    nxt_split = split;
    if (bus.flush) begin
      nxt_pending = '1;
      nxt_split = 1'b0;
    end else if (|(cand & (lu1 | lu2))) stall = 1'b1;
    else if (hit) begin
      issue = cand & keep;
      stall = 1'b1;
      nxt_pending = ~keep;
      nxt_split = 1'b1;
    end else begin
      issue = cand;
      nxt_pending = '1;
      nxt_split = 1'b0;
    end
  end
  // a flush leaves issue at zero, so only MEM needs explicit clearing
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_w <= '0;
      ex_ld <= '0;
      ex_rd <= '0;
      mem_w <= '0;
      mem_rd <= '0;
      fwd1 <= '0;
      fwd2 <= '0;
      split <= 1'b0;
      pending <= '1;
      cnt <= '0;
    end else begin
      ex_w <= issue & wr;
      ex_ld <= issue & ld;
      ex_rd <= bus.id_rd;
      mem_w <= bus.flush ? '0 : ex_w;
      mem_rd <= ex_rd;
      for (int l = 0; l < LANES; l++) begin
        fwd1[l] <= issue[l] ? {st1[l], ln1[l]} : '0;
        fwd2[l] <= issue[l] ? {st2[l], ln2[l]} : '0;
      end
      split <= nxt_split;
      pending <= nxt_pending;
      cnt <= cnt + 16'(stall && cnt != 16'hFFFF);
    end
  assign bus.issue_mask = issue;
  assign bus.stall = stall;
  assign bus.ex_fwd_rs1 = fwd1;
  assign bus.ex_fwd_rs2 = fwd2;
  assign bus.split_state = split;
  assign bus.stall_cycles = cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed bundles with per-cycle expectations queued at drive time, checked mid-cycle.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;
  typedef struct {
    string       tag;
    logic [1:0]  issue;
    logic        stall;
    logic        split;
    logic [5:0]  f1;
    logic [5:0]  f2;
    logic [15:0] sc;
  } exp_t;
  localparam logic [6:0] R = OP_R_TYPE, I = OP_I_IMME, L = OP_LOAD;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0, n_bad = 0;
  exp_t q[$];
  hazard_scoreboard_if #(.LANES(2)) bus();
  hazard_scoreboard #(.LANES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drv(input string tag, input logic rp, input logic fl, input logic [1:0] v,
                     input logic [6:0] o0, input logic [4:0] d0, a0, b0,
                     input logic [6:0] o1, input logic [4:0] d1, a1, b1,
                     input logic [1:0] ei, input logic es, input logic esp,
                     input logic [5:0] f1, input logic [5:0] f2, input logic [15:0] sc);
    exp_t e;
    @(posedge clk);
    #1;
    bus.flush = fl;
    bus.id_valid = v;
    bus.id_op[0] = o0; bus.id_rd[0] = d0; bus.id_rs1[0] = a0; bus.id_rs2[0] = b0;
    bus.id_op[1] = o1; bus.id_rd[1] = d1; bus.id_rs1[1] = a1; bus.id_rs2[1] = b1;
    if (rp) begin
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
    end
    e.tag = tag; e.issue = ei; e.stall = es; e.split = esp; e.f1 = f1; e.f2 = f2; e.sc = sc;
    q.push_back(e);
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.tag, ".issue"}, 32'(bus.issue_mask), 32'(e.issue));
      chk({e.tag, ".stall"}, 32'(bus.stall), 32'(e.stall));
      chk({e.tag, ".split"}, 32'(bus.split_state), 32'(e.split));
      chk({e.tag, ".fwd1"}, 32'(bus.ex_fwd_rs1), 32'(e.f1));
      chk({e.tag, ".fwd2"}, 32'(bus.ex_fwd_rs2), 32'(e.f2));
      chk({e.tag, ".cycles"}, 32'(bus.stall_cycles), 32'(e.sc));
    end
  initial begin
    bus.flush = 1'b0;
    bus.id_valid = '0;
    bus.id_op = '0;
    bus.id_rd = '0;
    bus.id_rs1 = '0;
    bus.id_rs2 = '0;
    drv("rst",        0, 0, 2'b00, R, 0, 0, 0,  R, 0, 0, 0,  2'b00, 0, 0, 6'o00, 6'o00, 0);
    rst_n = 1'b1;
    drv("ex_issue",   0, 0, 2'b01, R, 5, 1, 2,  R, 0, 0, 0,  2'b01, 0, 0, 6'o00, 6'o00, 0);
    drv("ex_use",     0, 0, 2'b01, R, 6, 5, 0,  R, 0, 0, 0,  2'b01, 0, 0, 6'o00, 6'o00, 0);
    drv("ex_fwd",     0, 0, 2'b00, R, 0, 0, 0,  R, 0, 0, 0,  2'b00, 0, 0, 6'o02, 6'o00, 0);
    drv("pair_w",     0, 0, 2'b11, R, 7, 1, 2,  I, 7, 3, 0,  2'b11, 0, 0, 6'o00, 6'o00, 0);
    drv("pair_use",   0, 0, 2'b01, R, 8, 0, 7,  R, 0, 0, 0,  2'b01, 0, 0, 6'o00, 6'o00, 0);
    drv("pair_w2",    0, 0, 2'b11, R, 9, 1, 2,  I, 9, 3, 0,  2'b11, 0, 0, 6'o00, 6'o03, 0);
    drv("bubble",     0, 0, 2'b00, R, 0, 0, 0,  R, 0, 0, 0,  2'b00, 0, 0, 6'o00, 6'o00, 0);
    drv("mem_use",    0, 0, 2'b01, R, 10, 0, 9, R, 0, 0, 0,  2'b01, 0, 0, 6'o00, 6'o00, 0);
    drv("load_w",     0, 0, 2'b11, I, 11, 0, 0, L, 3, 1, 0,  2'b11, 0, 0, 6'o00, 6'o05, 0);
    drv("load_use",   0, 0, 2'b01, R, 12, 3, 0, R, 0, 0, 0,  2'b00, 1, 0, 6'o00, 6'o00, 0);
    drv("load_go",    0, 0, 2'b01, R, 12, 3, 0, R, 0, 0, 0,  2'b01, 0, 0, 6'o00, 6'o00, 1);
    drv("split1",     0, 0, 2'b11, I, 4, 1, 0,  R, 13, 2, 4, 2'b01, 1, 0, 6'o05, 6'o00, 1);
    drv("split2",     0, 0, 2'b11, I, 4, 1, 0,  R, 13, 2, 4, 2'b10, 0, 1, 6'o00, 6'o00, 2);
    drv("split_done", 0, 0, 2'b00, R, 0, 0, 0,  R, 0, 0, 0,  2'b00, 0, 0, 6'o00, 6'o20, 2);
    drv("pre_flush",  0, 0, 2'b11, I, 4, 13, 0, R, 13, 2, 4, 2'b01, 1, 0, 6'o00, 6'o00, 2);
    drv("flush",      0, 1, 2'b11, I, 4, 13, 0, R, 13, 2, 4, 2'b00, 0, 1, 6'o05, 6'o00, 3);
    drv("post_flush", 0, 0, 2'b11, I, 4, 13, 0, R, 13, 2, 4, 2'b01, 1, 0, 6'o00, 6'o00, 3);
    drv("post_flush2",0, 0, 2'b11, I, 4, 13, 0, R, 13, 2, 4, 2'b10, 0, 1, 6'o00, 6'o00, 4);
    drv("pre_rst",    0, 0, 2'b11, I, 4, 13, 0, R, 13, 2, 4, 2'b01, 1, 0, 6'o00, 6'o20, 4);
    drv("rst_pulse",  1, 0, 2'b11, I, 4, 13, 0, R, 13, 2, 4, 2'b01, 1, 0, 6'o00, 6'o00, 0);
    drv("post_rst",   0, 0, 2'b11, I, 4, 13, 0, R, 13, 2, 4, 2'b10, 0, 1, 6'o00, 6'o00, 1);
    drv("post_rst_r", 0, 0, 2'b00, R, 0, 0, 0,  R, 0, 0, 0,  2'b00, 0, 0, 6'o00, 6'o20, 1);
    drv("rd0",        0, 0, 2'b11, R, 0, 1, 2,  R, 14, 0, 0, 2'b11, 0, 0, 6'o00, 6'o00, 1);
    drv("rd0_use",    0, 0, 2'b01, R, 15, 0, 14, R, 0, 0, 0, 2'b01, 0, 0, 6'o00, 6'o00, 1);
    drv("rd0_fwd",    0, 0, 2'b00, R, 0, 0, 0,  R, 0, 0, 0,  2'b00, 0, 0, 6'o00, 6'o03, 1);
    repeat (2) @(posedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
